// File: rtl/crc_fprint_buffer_if.sv
// rtl/crc_fprint_buffer_if.sv - fingerprint write and comparator directory bus for crc_fprint_buffer
interface crc_fprint_buffer_if #(
  parameter int CW = 32,
  parameter int KW = 4,
  parameter int SW = 4
);
  logic              fp_valid;
  logic [CW-1:0]     fp_data;
  logic [KW-1:0]     fp_task;
  logic [KW-1:0]     dir_adr_r;
  logic              ram_adr_load;
  logic              increment_dir_address;
  logic              fprints_checked;
  logic              task_clr;
  logic [KW-1:0]     task_clr_key;
  logic [CW-1:0]     crc_out;
  logic [SW-1:0]     head_pointer;
  logic [SW-1:0]     tail_pointer;
  logic [2**KW-1:0]  fprints_ready;
  logic [2**KW-1:0]  overflow;
  logic              dir_w_ack;

  modport master (
    output fp_valid, fp_data, fp_task, dir_adr_r, ram_adr_load,
           increment_dir_address, fprints_checked, task_clr, task_clr_key,
    input  crc_out, head_pointer, tail_pointer, fprints_ready, overflow, dir_w_ack
  );

  modport slave (
    input  fp_valid, fp_data, fp_task, dir_adr_r, ram_adr_load,
           increment_dir_address, fprints_checked, task_clr, task_clr_key,
    output crc_out, head_pointer, tail_pointer, fprints_ready, overflow, dir_w_ack
  );
endinterface

// File: rtl/crc_fprint_buffer.sv
// rtl/crc_fprint_buffer.sv - per-core fingerprint RAM with per-task circular FIFO directory
module crc_fprint_buffer #(
  parameter int CW = 32,
  parameter int KW = 4,
  parameter int SW = 4
) (
  input  logic               clk,
  input  logic               rst,
  crc_fprint_buffer_if.slave bus
);
  localparam int NT    = 2**KW;
  localparam int DEPTH = 2**(KW+SW);

  logic [SW-1:0]    head [NT];
  logic [SW-1:0]    tail [NT];
  logic [CW-1:0]    mem  [DEPTH];
  logic [KW+SW-1:0] rd_adr;
  logic             rd_pend;
  logic [CW-1:0]    crc_q;
  logic             ack_q;
  logic [NT-1:0]    ready_q, ovf_q, ready_nxt, ovf_nxt;
  logic [SW-1:0]    wr_head, wr_tail, dir_head, dir_tail, dir_tail_nxt;
  logic             wr_full, clr_wr, clr_dir, wr_ok, drop, pop_ok;

  // All decisions use pointer values from before this edge; a clear of the same task overrides.
  always_comb begin
    wr_head      = head[bus.fp_task];
    wr_tail      = tail[bus.fp_task];
    dir_head     = head[bus.dir_adr_r];
    dir_tail     = tail[bus.dir_adr_r];
    wr_full      = (wr_head + SW'(1)) == wr_tail;
    clr_wr       = bus.task_clr && (bus.task_clr_key == bus.fp_task);
    clr_dir      = bus.task_clr && (bus.task_clr_key == bus.dir_adr_r);
    wr_ok        = bus.fp_valid && !wr_full && !clr_wr;
    drop         = bus.fp_valid && wr_full && !clr_wr;
    pop_ok       = bus.increment_dir_address && (dir_head != dir_tail) && !clr_dir;
    dir_tail_nxt = clr_dir ? '0 : (pop_ok ? dir_tail + SW'(1) : dir_tail);

    ready_nxt = ready_q;
    ovf_nxt   = ovf_q;
    if (bus.fprints_checked) ready_nxt[bus.dir_adr_r] = 1'b0;
    if (wr_ok)               ready_nxt[bus.fp_task]   = 1'b1;
    if (drop)                ovf_nxt[bus.fp_task]     = 1'b1;
    if (bus.task_clr) begin
      ready_nxt[bus.task_clr_key] = 1'b0;
      ovf_nxt[bus.task_clr_key]   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NT; i++) begin
        head[i] <= '0;
        tail[i] <= '0;
      end
      ready_q <= '0;
      ovf_q   <= '0;
      ack_q   <= 1'b0;
      rd_adr  <= '0;
      rd_pend <= 1'b0;
      crc_q   <= '0;
    end else begin
      if (wr_ok)  head[bus.fp_task]   <= wr_head + SW'(1);
      if (pop_ok) tail[bus.dir_adr_r] <= dir_tail + SW'(1);
      if (bus.task_clr) begin
        head[bus.task_clr_key] <= '0;
        tail[bus.task_clr_key] <= '0;
      end
      ready_q <= ready_nxt;
      ovf_q   <= ovf_nxt;
      ack_q   <= bus.task_clr;
      // The read address follows a coincident pop so load+pop fetches the new tail entry.
      rd_pend <= bus.ram_adr_load;
      if (bus.ram_adr_load) rd_adr <= {bus.dir_adr_r, dir_tail_nxt};
      if (rd_pend)          crc_q  <= mem[rd_adr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[{bus.fp_task, wr_head}] <= bus.fp_data;
  end

  assign bus.crc_out       = crc_q;
  assign bus.head_pointer  = dir_head;
  assign bus.tail_pointer  = dir_tail;
  assign bus.fprints_ready = ready_q;
  assign bus.overflow      = ovf_q;
  assign bus.dir_w_ack     = ack_q;
endmodule

// File: tb/tb_crc_fprint_buffer.sv
// tb/tb_crc_fprint_buffer.sv - directed self-checking bench for crc_fprint_buffer
module tb_crc_fprint_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  crc_fprint_buffer_if #(.CW(32), .KW(4), .SW(4)) b ();

  crc_fprint_buffer #(.CW(32), .KW(4), .SW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] t, input logic [31:0] d);
    b.fp_valid = 1'b1;
    b.fp_task  = t;
    b.fp_data  = d;
    tick();
    b.fp_valid = 1'b0;
  endtask

  task automatic load_and_wait();
    b.ram_adr_load = 1'b1;
    tick();
    b.ram_adr_load = 1'b0;
    tick();
  endtask

  initial begin
    b.fp_valid = 0; b.fp_data = '0; b.fp_task = '0; b.dir_adr_r = '0;
    b.ram_adr_load = 0; b.increment_dir_address = 0; b.fprints_checked = 0;
    b.task_clr = 0; b.task_clr_key = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Traffic, then reset lands while an ack is outstanding.
    wr(4'd3, 32'h33);
    wr(4'd3, 32'h34);
    b.task_clr = 1; b.task_clr_key = 4'd7; b.fp_valid = 1; b.fp_task = 4'd9; b.fp_data = 32'h99;
    tick();
    chk("ack_before_reset", b.dir_w_ack, 1);
    rst = 1'b1;
    #1;
    chk("ack_async_reset", b.dir_w_ack, 0);
    tick();
    b.task_clr = 0; b.fp_valid = 0;
    chk("rst_ready", b.fprints_ready, 0);
    chk("rst_overflow", b.overflow, 0);
    chk("rst_ack", b.dir_w_ack, 0);
    chk("rst_crc", b.crc_out, 0);
    for (int t = 0; t < 16; t++) begin
      b.dir_adr_r = t[3:0];
      #1;
      chk($sformatf("rst_head_%0d", t), b.head_pointer, 0);
      chk($sformatf("rst_tail_%0d", t), b.tail_pointer, 0);
    end
    rst = 1'b0;
    tick();

    // Three writes to task 2, then readback.
    wr(4'd2, 32'hA);
    wr(4'd2, 32'hB);
    wr(4'd2, 32'hC);
    b.dir_adr_r = 4'd2;
    #1;
    chk("t2_head", b.head_pointer, 3);
    chk("t2_tail", b.tail_pointer, 0);
    chk("t2_ready", b.fprints_ready, 32'h0004);
    load_and_wait();
    chk("t2_crc_a", b.crc_out, 32'hA);
    b.increment_dir_address = 1; b.ram_adr_load = 1;
    tick();
    b.increment_dir_address = 0; b.ram_adr_load = 0;
    tick();
    chk("t2_tail_pop", b.tail_pointer, 1);
    chk("t2_crc_b", b.crc_out, 32'hB);

    // Fill task 5 to capacity, then overflow.
    for (int i = 0; i < 15; i++) wr(4'd5, 32'h500 + i);
    b.dir_adr_r = 4'd5;
    #1;
    chk("t5_head_full", b.head_pointer, 15);
    wr(4'd5, 32'h5FF);
    chk("t5_head_drop", b.head_pointer, 15);
    chk("t5_overflow", b.overflow, 32'h0020);
    chk("t5_ready", b.fprints_ready, 32'h0024);
    b.increment_dir_address = 1;
    wr(4'd5, 32'h5EE);
    b.increment_dir_address = 0;
    chk("t5_pop_tail", b.tail_pointer, 1);
    chk("t5_pop_write_dropped", b.head_pointer, 15);
    wr(4'd5, 32'h510);
    chk("t5_head_wrap", b.head_pointer, 0);
    load_and_wait();
    chk("t5_crc_slot1", b.crc_out, 32'h501);

    // Check vs coincident write on task 2.
    b.dir_adr_r = 4'd2;
    b.fprints_checked = 1;
    wr(4'd2, 32'hD);
    b.fprints_checked = 0;
    chk("chk_write_wins", b.fprints_ready, 32'h0024);
    b.fprints_checked = 1;
    tick();
    b.fprints_checked = 0;
    chk("chk_clears", b.fprints_ready, 32'h0020);

    // Clear task 5 against a coincident write.
    b.dir_adr_r = 4'd5;
    b.task_clr = 1; b.task_clr_key = 4'd5;
    #1;
    chk("clr_ack_pre", b.dir_w_ack, 0);
    wr(4'd5, 32'h777);
    b.task_clr = 0;
    chk("clr_ack", b.dir_w_ack, 1);
    chk("clr_head", b.head_pointer, 0);
    chk("clr_tail", b.tail_pointer, 0);
    chk("clr_overflow", b.overflow, 0);
    chk("clr_ready", b.fprints_ready, 0);
    tick();
    chk("clr_ack_gone", b.dir_w_ack, 0);
    b.task_clr = 1; b.task_clr_key = 4'd1;
    tick();
    chk("clr_hold_ack1", b.dir_w_ack, 1);
    tick();
    b.task_clr = 0;
    chk("clr_hold_ack2", b.dir_w_ack, 1);
    tick();
    chk("clr_hold_ack_end", b.dir_w_ack, 0);

    // Interleave tasks 0 and 15, then read both back in order.
    for (int i = 0; i < 10; i++) wr((i % 2 == 0) ? 4'd0 : 4'd15, 32'h100 + i);
    for (int t = 0; t < 2; t++) begin
      b.dir_adr_r = (t == 0) ? 4'd0 : 4'd15;
      #1;
      chk($sformatf("il_head_%0d", b.dir_adr_r), b.head_pointer, 5);
      for (int k = 0; k < 5; k++) begin
        load_and_wait();
        chk($sformatf("il_crc_%0d_%0d", b.dir_adr_r, k), b.crc_out, 32'h100 + 2 * k + t);
        b.increment_dir_address = 1;
        tick();
        b.increment_dir_address = 0;
      end
      chk($sformatf("il_tail_%0d", b.dir_adr_r), b.tail_pointer, 5);
    end
    b.dir_adr_r = 4'd0;
    b.increment_dir_address = 1;
    tick();
    b.increment_dir_address = 0;
    chk("empty_pop_tail", b.tail_pointer, 5);
    chk("empty_pop_head", b.head_pointer, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
